hwpe_ctrl_offload_master: RTL
=============================

Name: hwpe_ctrl_offload_master

Overview:
Initiator side of the hwpe_ctrl peripheral protocol. It drives one complete job offload to an HWPE control slave on behalf of a local requester, such as a DMA-less test harness or a companion controller.
- Sequence: acquire (read register 1), program job registers, trigger (write register 0), then wait for the completion event.
- Sits between a simple command port and the cfg peripheral bus of the slave.

Parameters:
ID_WIDTH, 16, width of transaction id / core-one-hot id driven on id
N_JOB_REGS, 8, maximum job registers written per offload (1..32)
JOB_REG_OFFSET, 8, register index of the first job register
MY_ID, 1, value driven on id_o for every transaction
BACKOFF_CYCLES, 4, idle cycles between a failed acquire and the retry (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous active-low
cmd_valid_i  in  1  offload request
cmd_ready_o  out  1  block can accept a command
cmd_nregs_i  in  $clog2(N_JOB_REGS)+1  number of job registers to write (0..N_JOB_REGS)
cmd_regs_i  in  N_JOB_REGS*32  job register values, reg k at bits [32k+31:32k]
done_o  out  1  one-cycle pulse when the job completes
job_id_o  out  8  context id returned by acquire, valid while busy_o and at done_o
busy_o  out  1  offload in progress
req_o  out  1  periph request
gnt_i  in  1  periph grant
add_o  out  32  byte address, register index*4
wen_o  out  1  1=read, 0=write
be_o  out  4  byte enables, always 4'hF
data_o  out  32  write data
id_o  out  ID_WIDTH  transaction id
r_data_i  in  32  read data
r_valid_i  in  1  response valid, one per transaction including writes
r_id_i  in  ID_WIDTH  response id
evt_i  in  1  completion event from the slave, pulse

Behaviour:
Clocking and reset:
- Single clock, clk_i. Reset is synchronous and active-low on rst_ni; all state updates on the rising edge of clk_i.
- Reset values: req_o=0, add_o=0, wen_o=1, data_o=0, id_o=MY_ID, be_o=4'hF, done_o=0, busy_o=0, job_id_o=0. cmd_ready_o=1 on the first cycle after reset.

Bus rules:
- At most one outstanding transaction.
- req_o and add/wen/data stay stable until the cycle gnt_i=1.
- req_o drops the cycle after a grant.
- The FSM then waits for r_valid_i with r_id_i==MY_ID. Responses with other ids are ignored.

FSM states:
- IDLE: cmd_ready_o=1. On cmd_valid_i, latch cmd_nregs_i and cmd_regs_i, then go to ACQ.
- ACQ: read index 1 (add_o=0x4, wen_o=1). On response:
  - r_data_i[31]==1 (no free context): go to BACKOFF.
  - otherwise: job_id_o<=r_data_i[7:0], reg counter<=0, go to CFG (or TRIG if nregs==0).
- BACKOFF: count down BACKOFF_CYCLES, then return to ACQ.
- CFG: write index JOB_REG_OFFSET+k with cmd_regs[k]. On response:
  - k==nregs-1: go to TRIG.
  - otherwise: k++.
- TRIG: write index 0, data 0. On response go to WAIT_EVT.
- WAIT_EVT: on evt_i, done_o pulses for 1 cycle, then go to IDLE.

Status and boundaries:
- busy_o=1 in every state except IDLE.
- An evt_i pulse outside WAIT_EVT is dropped.
- If evt_i arrives in the same cycle as the trigger response, it is captured in a sticky bit; done_o fires the next cycle.
- cmd_nregs_i > N_JOB_REGS is saturated to N_JOB_REGS.
- cmd_valid_i while busy is ignored.
- rst_ni=0 mid-transaction returns every output to its reset value on the next edge. No bus clean-up is performed.

Optional Feature:
HWPE_OFFLOAD_TIMEOUT_EN
- Defined:
  - A 16-bit watchdog counts cycles in WAIT_EVT.
  - At 0xFFFF it issues a write to index 5 (soft clear, data 0), waits for its response, pulses done_o with error_o=1, then returns to IDLE.
  - Port error_o (out, 1) is added; its reset value is 0. It is high only together with done_o.
- Undefined: no watchdog and no error_o port. WAIT_EVT waits indefinitely.

Test Plan:
1. Acquire returns 0x0, nregs=2, regs {0xA,0xB}, slave grants immediately, r_valid 1 cycle later -> transaction sequence rd 0x4, wr 0x20=0xA, wr 0x24=0xB, wr 0x0=0; evt_i 10 cycles later -> done_o 1 cycle, job_id_o=0.
2. Acquire returns 0xFFFFFFFF twice, then 0x1 -> three reads of 0x4, each retry >= BACKOFF_CYCLES+1 cycles apart; job_id_o=1.
3. gnt_i held low 5 cycles on a CFG write -> req_o/add_o/data_o stable for all 5 cycles, exactly one write issued.
4. Response with r_id_i!=MY_ID injected during ACQ -> ignored; FSM advances only on the matching id.
5. nregs=0 -> acquire then trigger, no job writes; evt_i coincident with the trigger response -> done_o the next cycle.
6. rst_ni=0 during CFG -> next edge req_o=0, busy_o=0; after reset a new command completes normally. With HWPE_OFFLOAD_TIMEOUT_EN defined and no evt_i -> write to 0x14 after 65535 cycles, done_o=1, error_o=1.

Source files
------------

// File: rtl/hwpe_ctrl_offload_master.sv
// rtl/hwpe_ctrl_offload_master.sv - initiator that offloads one job to an hwpe_ctrl slave
//
// Purpose: takes one command (job register count + values) and runs it on the slave's
// cfg peripheral bus: acquire (read reg 1, retry after a backoff while the slave has no
// free context), write the job registers, trigger (write reg 0), then wait for the
// completion event and pulse done_o.
//
// Ports:
//   clk_i, rst_ni                   clock, synchronous active-low reset
//   cmd_valid_i / cmd_ready_o       command handshake
//   cmd_nregs_i, cmd_regs_i         job register count and packed values (reg k at [32k+31:32k])
//   done_o, job_id_o, busy_o        completion pulse, acquired context id, offload in progress
//   req_o/gnt_i/add_o/wen_o/be_o/
//   data_o/id_o                     peripheral request channel (wen_o=1 is a read)
//   r_data_i/r_valid_i/r_id_i       peripheral response channel
//   evt_i                           completion event pulse from the slave
//   error_o                         (HWPE_OFFLOAD_TIMEOUT_EN only) high with done_o on a watchdog abort
//
// Optional feature macro: HWPE_OFFLOAD_TIMEOUT_EN adds a 16-bit watchdog on the event wait
// that soft-clears the slave (write to reg 5) and finishes the offload with error_o=1.

module hwpe_ctrl_offload_master #(
   parameter int unsigned ID_WIDTH       = 16,
   parameter int unsigned N_JOB_REGS     = 8,
   parameter int unsigned JOB_REG_OFFSET = 8,
   parameter int unsigned MY_ID          = 1,
   parameter int unsigned BACKOFF_CYCLES = 4,
   localparam int unsigned NW            = $clog2(N_JOB_REGS) + 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic [NW-1:0]           cmd_nregs_i,
   input  logic [N_JOB_REGS*32-1:0] cmd_regs_i,
   output logic                    done_o,
   output logic [7:0]              job_id_o,
   output logic                    busy_o,
   output logic                    req_o,
   input  logic                    gnt_i,
   output logic [31:0]             add_o,
   output logic                    wen_o,
   output logic [3:0]              be_o,
   output logic [31:0]             data_o,
   output logic [ID_WIDTH-1:0]     id_o,
   input  logic [31:0]             r_data_i,
   input  logic                    r_valid_i,
   input  logic [ID_WIDTH-1:0]     r_id_i,
   input  logic                    evt_i
`ifdef HWPE_OFFLOAD_TIMEOUT_EN
   ,
   output logic                    error_o
`endif
);

   localparam int unsigned BW = $clog2(BACKOFF_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACQ,
      S_BACKOFF,
      S_CFG,
      S_TRIG,
      S_WAIT_EVT,
      S_CLEAR
   } state_t;

   state_t                  state_q;
   logic                    pend_q;     // granted, response not yet seen
   logic                    evt_q;      // event that coincided with the trigger response
   logic [NW-1:0]           nregs_q;
   logic [NW-1:0]           k_q;
   logic [BW-1:0]           bo_cnt_q;
   logic [N_JOB_REGS*32-1:0] regs_q;
`ifdef HWPE_OFFLOAD_TIMEOUT_EN
   logic [15:0]             wd_q;
`endif

   logic          rsp_ok;
   logic [NW-1:0] nregs_sat;
   logic [NW-1:0] k_nxt;
   logic          unused_rdata;

   assign be_o   = 4'hF;
   assign id_o   = ID_WIDTH'(MY_ID);
   assign rsp_ok = pend_q && r_valid_i && (r_id_i == ID_WIDTH'(MY_ID));
   assign nregs_sat = (cmd_nregs_i > NW'(N_JOB_REGS)) ? NW'(N_JOB_REGS) : cmd_nregs_i;
   assign k_nxt  = k_q + NW'(1);
   assign unused_rdata = ^r_data_i[30:8];

   function automatic logic [31:0] job_addr(input logic [NW-1:0] k);
      return (32'(JOB_REG_OFFSET) + 32'(k)) << 2;
   endfunction

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         req_o       <= 1'b0;
         add_o       <= 32'h0;
         wen_o       <= 1'b1;
         data_o      <= 32'h0;
         done_o      <= 1'b0;
         busy_o      <= 1'b0;
         job_id_o    <= 8'h0;
         cmd_ready_o <= 1'b1;
         pend_q      <= 1'b0;
         evt_q       <= 1'b0;
         nregs_q     <= '0;
         k_q         <= '0;
         bo_cnt_q    <= '0;
`ifdef HWPE_OFFLOAD_TIMEOUT_EN
         wd_q        <= 16'h0;
         error_o     <= 1'b0;
`endif
      end else begin
         done_o <= 1'b0;
`ifdef HWPE_OFFLOAD_TIMEOUT_EN
         error_o <= 1'b0;
`endif
         // Request phase ends on grant; the response phase ends on a matching response.
         if (req_o && gnt_i) begin
            req_o  <= 1'b0;
            pend_q <= 1'b1;
         end
         if (rsp_ok) pend_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (cmd_valid_i) begin
                  nregs_q     <= nregs_sat;
                  regs_q      <= cmd_regs_i;
                  state_q     <= S_ACQ;
                  req_o       <= 1'b1;
                  add_o       <= 32'h4;
                  wen_o       <= 1'b1;
                  data_o      <= 32'h0;
                  busy_o      <= 1'b1;
                  cmd_ready_o <= 1'b0;
               end
            end
            S_ACQ: begin
               if (rsp_ok) begin
                  if (r_data_i[31]) begin
                     state_q  <= S_BACKOFF;
                     bo_cnt_q <= BW'(BACKOFF_CYCLES);
                  end else begin
                     job_id_o <= r_data_i[7:0];
                     k_q      <= '0;
                     req_o    <= 1'b1;
                     wen_o    <= 1'b0;
                     if (nregs_q == '0) begin
                        state_q <= S_TRIG;
                        add_o   <= 32'h0;
                        data_o  <= 32'h0;
                     end else begin
                        state_q <= S_CFG;
                        add_o   <= job_addr('0);
                        data_o  <= regs_q[31:0];
                     end
                  end
               end
            end
            S_BACKOFF: begin
               if (bo_cnt_q <= BW'(1)) begin
                  state_q <= S_ACQ;
                  req_o   <= 1'b1;
                  add_o   <= 32'h4;
                  wen_o   <= 1'b1;
                  data_o  <= 32'h0;
               end else begin
                  bo_cnt_q <= bo_cnt_q - BW'(1);
               end
            end
            S_CFG: begin
               if (rsp_ok) begin
                  req_o <= 1'b1;
                  if (k_q == nregs_q - NW'(1)) begin
                     state_q <= S_TRIG;
                     add_o   <= 32'h0;
                     data_o  <= 32'h0;
                  end else begin
                     k_q    <= k_nxt;
                     add_o  <= job_addr(k_nxt);
                     data_o <= regs_q[32*int'(k_nxt) +: 32];
                  end
               end
            end
            S_TRIG: begin
               if (rsp_ok) begin
                  state_q <= S_WAIT_EVT;
                  // The slave may finish instantly; keep that event for the next cycle.
                  evt_q   <= evt_i;
`ifdef HWPE_OFFLOAD_TIMEOUT_EN
                  wd_q    <= 16'h0;
`endif
               end
            end
            S_WAIT_EVT: begin
               if (evt_i || evt_q) begin
                  state_q     <= S_IDLE;
                  evt_q       <= 1'b0;
                  done_o      <= 1'b1;
                  busy_o      <= 1'b0;
                  cmd_ready_o <= 1'b1;
               end
`ifdef HWPE_OFFLOAD_TIMEOUT_EN
               else if (wd_q == 16'hFFFF) begin
                  state_q <= S_CLEAR;
                  req_o   <= 1'b1;
                  add_o   <= 32'h14;
                  wen_o   <= 1'b0;
                  data_o  <= 32'h0;
               end else begin
                  wd_q <= wd_q + 16'h1;
               end
`endif
            end
            S_CLEAR: begin
`ifdef HWPE_OFFLOAD_TIMEOUT_EN
               if (rsp_ok) begin
                  state_q     <= S_IDLE;
                  done_o      <= 1'b1;
                  error_o     <= 1'b1;
                  busy_o      <= 1'b0;
                  cmd_ready_o <= 1'b1;
               end
`else
               state_q <= S_IDLE;
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
